muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/mips_pkg.sv | 30 +++
 rtl/muldiv_datapath.sv | 65 ++++++
 rtl/muldiv_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: ALU control width plus the multiply/divide unit types.
package mips_pkg;

  localparam int unsigned ALU_CTRL_WIDTH = 4;

  // Multiply/divide unit
  localparam int unsigned MD_OP_WIDTH  = 2;
  localparam int unsigned MD_XLEN      = 32;
  localparam int unsigned MD_ITER      = 32;
  localparam int unsigned MD_CNT_WIDTH = $clog2(MD_ITER);

  typedef enum logic [MD_OP_WIDTH-1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } md_state_t;

  // Two's-complement magnitude when neg is set, pass-through otherwise.
  function automatic logic [MD_XLEN-1:0] md_mag(input logic [MD_XLEN-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative unsigned multiply / restoring-divide datapath, one bit per step.
// Multiply: acc = {partial product, remaining multiplier bits}, opnd = multiplicand.
// Divide:   acc = {partial remainder, remaining dividend / quotient bits}, opnd = divisor.
module muldiv_datapath
  import mips_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic                 is_div_i,
  input  logic [MD_XLEN-1:0]   a_mag_i,
  input  logic [MD_XLEN-1:0]   b_mag_i,
  output logic [2*MD_XLEN-1:0] acc_o
);

  logic [2*MD_XLEN-1:0] acc_q, acc_d;
  logic [MD_XLEN-1:0]   opnd_q, opnd_d;
  logic [MD_XLEN:0]     mul_sum;
  logic [MD_XLEN+1:0]   div_diff;
  logic [2*MD_XLEN-1:0] step_res;

  // Single iteration: conditional add-and-shift-right, or shift-left-and-trial-subtract.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*MD_XLEN-1:MD_XLEN]} +
               {1'b0, (acc_q[0] ? opnd_q : {MD_XLEN{1'b0}})};
    // Shifted remainder needs 33 bits because a divisor >= 2^31 can leave bit 31 set.
    div_diff = {1'b0, acc_q[2*MD_XLEN-1:MD_XLEN-1]} - {2'b00, opnd_q};
    if (is_div_i) begin
      if (div_diff[MD_XLEN+1]) begin
        step_res = {acc_q[2*MD_XLEN-2:0], 1'b0};
      end else begin
        step_res = {div_diff[MD_XLEN-1:0], acc_q[MD_XLEN-2:0], 1'b1};
      end
    end else begin
      step_res = {mul_sum, acc_q[MD_XLEN-1:1]};
    end
  end

  // Load operands on accept, otherwise advance one iteration while stepping.
  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    if (load_i) begin
      acc_d  = {{MD_XLEN{1'b0}}, (is_div_i ? a_mag_i : b_mag_i)};
      opnd_d = is_div_i ? b_mag_i : a_mag_i;
    end else if (step_i) begin
      acc_d = step_res;
    end
  end

  // Accumulator and iteration operand registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      opnd_q <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// MIPS HI/LO multiply/divide unit: 32-cycle iterative MULT/MULTU/DIV/DIVU with MTHI/MTLO.
module muldiv_unit
  import mips_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [MD_OP_WIDTH-1:0] md_op,
  input  logic [MD_XLEN-1:0]     operand_a,
  input  logic [MD_XLEN-1:0]     operand_b,
  input  logic                   hi_we,
  input  logic                   lo_we,
  input  logic [MD_XLEN-1:0]     wdata,
  output logic [MD_XLEN-1:0]     hi,
  output logic [MD_XLEN-1:0]     lo,
  output logic                   busy,
  output logic                   done,
  output logic                   div_by_zero
);

  md_state_t               state_q;
  md_op_t                  op_q;
  logic [MD_CNT_WIDTH-1:0] cnt_q;
  logic                    neg_res_q;
  logic                    neg_rem_q;
  logic                    zdiv_q;
  logic [MD_XLEN-1:0]      hi_q, lo_q;
  logic                    done_q, dbz_q;

  logic                    accept;
  logic                    in_signed, in_div, a_neg, b_neg, zero_div;
  logic                    op_is_div;
  logic                    dp_is_div;
  logic [MD_XLEN-1:0]      a_mag, b_mag;
  logic [2*MD_XLEN-1:0]    acc;
  logic [2*MD_XLEN-1:0]    prod_fixed;
  logic [MD_XLEN-1:0]      quo_fixed, rem_fixed;
  logic [MD_XLEN-1:0]      fix_hi, fix_lo;

  // Decode the incoming request and form operand magnitudes.
  always_comb begin
    accept    = start && (state_q == IDLE);
    in_signed = (md_op == MD_MULT) || (md_op == MD_DIV);
    in_div    = (md_op == MD_DIV) || (md_op == MD_DIVU);
    a_neg     = in_signed & operand_a[MD_XLEN-1];
    b_neg     = in_signed & operand_b[MD_XLEN-1];
    zero_div  = in_div && (operand_b == '0);
    a_mag     = md_mag(operand_a, a_neg);
    b_mag     = md_mag(operand_b, b_neg);
    op_is_div = (op_q == MD_DIV) || (op_q == MD_DIVU);
    // The datapath sees the live op while loading and the latched op while iterating.
    dp_is_div = accept ? in_div : op_is_div;
  end

  muldiv_datapath u_datapath (
    .clk_i    (clk),
    .rst_i    (rst),
    .load_i   (accept && !zero_div),
    .step_i   (state_q == CALC),
    .is_div_i (dp_is_div),
    .a_mag_i  (a_mag),
    .b_mag_i  (b_mag),
    .acc_o    (acc)
  );

  // Sign correction of the unsigned iteration result, applied in FIX.
  always_comb begin
    prod_fixed = neg_res_q ? (~acc + 1'b1) : acc;
    quo_fixed  = md_mag(acc[MD_XLEN-1:0], neg_res_q);
    rem_fixed  = md_mag(acc[2*MD_XLEN-1:MD_XLEN], neg_rem_q);
    if (op_is_div) begin
      fix_hi = rem_fixed;
      fix_lo = quo_fixed;
    end else begin
      fix_hi = prod_fixed[2*MD_XLEN-1:MD_XLEN];
      fix_lo = prod_fixed[MD_XLEN-1:0];
    end
  end

  // Control FSM, iteration counter, HI/LO registers and registered status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= MD_MULT;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zdiv_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start) begin
            op_q      <= md_op_t'(md_op);
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            zdiv_q    <= zero_div;
            cnt_q     <= '0;
            state_q   <= zero_div ? FIX : CALC;
          end
        end
        CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == MD_CNT_WIDTH'(MD_ITER - 1)) state_q <= FIX;
        end
        FIX: begin
          // A divide by zero retires without touching HI/LO.
          if (!zdiv_q) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
          end
          done_q  <= 1'b1;
          dbz_q   <= zdiv_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule
